// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL supervisor / staged reset sequencer.
package pll_rst_seq_pkg;

  // Sequencer states; the encoding is visible on state_o.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // Width of the shared state counter: it must hold the largest terminal
  // count any state compares against.
  function automatic int cnt_width(input int n_ch,
                                   input int lock_timeout,
                                   input int stable_cycles,
                                   input int stage_gap,
                                   input int pll_rst_cycles);
    int m;
    m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (stage_gap * (n_ch - 1) + 1 > m) m = stage_gap * (n_ch - 1) + 1;
    if (pll_rst_cycles > m) m = pll_rst_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Multi-stage synchroniser for a single asynchronous bit, cleared to 0 on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL supervisor: drives the rPLL reset, qualifies lock, then releases the
// downstream reset channels one by one. Re-sequences on lock loss or sw_rst.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 256,
  parameter int CNT_W          = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             pll_lock_i,
  input  logic             sw_rst_i,
  output logic             pll_rst_o,
  output logic [N_CH-1:0]  ch_rst_n_o,
  output logic             ready_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o
);

  localparam int CW = cnt_width(N_CH, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP, PLL_RST_CYCLES);

  // Terminal counts: a state exits on the cycle its counter reads these.
  localparam logic [CW-1:0]    PRC_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    REL_LAST = CW'(STAGE_GAP * (N_CH - 1));
  localparam logic [CNT_W-1:0] DBG_MAX  = {CNT_W{1'b1}};

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [N_CH-1:0]   ch_next;
  logic [N_CH-1:0]   rel_hit;
  logic [CNT_W-1:0]  llc_next, rc_next;
  logic              lock_sync;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_sync)
  );

  // Next state, shared counter and debug counters; sw_rst overrides everything.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    llc_next   = lock_loss_cnt_o;
    rc_next    = retry_cnt_o;
    if (sw_rst_i) begin
      state_next = ST_PLL_RST;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == PRC_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync) begin
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else if (cnt == TO_LAST) begin
            state_next = ST_PLL_RST;
            cnt_next   = '0;
            if (retry_cnt_o != DBG_MAX) rc_next = retry_cnt_o + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_sync) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == STB_LAST) begin
            state_next = ST_RELEASE;
            cnt_next   = '0;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_sync) begin
            // Lock lost after release: drop channels, wait for lock again
            // without touching the PLL reset.
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
            if (lock_loss_cnt_o != DBG_MAX) llc_next = lock_loss_cnt_o + CNT_W'(1);
          end else if (state == ST_RELEASE && cnt == REL_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else if (state == ST_RUN) begin
            cnt_next = cnt;
          end
        end
        default: begin
          state_next = ST_PLL_RST;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Channel i is due for release when the RELEASE counter reaches STAGE_GAP*i.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rel_hit
      assign rel_hit[gi] = (cnt_next == CW'(STAGE_GAP * gi));
    end
  endgenerate

  // Channel resets follow the next state so they are registered with it.
  always_comb begin
    ch_next = '0;
    case (state_next)
      ST_RELEASE: ch_next = ch_rst_n_o | rel_hit;
      ST_RUN:     ch_next = '1;
      default:    ch_next = '0;
    endcase
  end

  // State, counter, outputs and debug counters.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_PLL_RST;
      cnt             <= '0;
      pll_rst_o       <= 1'b1;
      ch_rst_n_o      <= '0;
      ready_o         <= 1'b0;
      lock_loss_cnt_o <= '0;
      retry_cnt_o     <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      pll_rst_o       <= (state_next == ST_PLL_RST);
      ch_rst_n_o      <= ch_next;
      ready_o         <= (state_next == ST_RUN);
      lock_loss_cnt_o <= llc_next;
      retry_cnt_o     <= rc_next;
    end
  end

  assign state_o = state;

endmodule
